// File: rtl/pong_pkg.sv
// Shared constants and types for the pong video core.
// Latency: n/a (package only).
// Backpressure: n/a.
//   Holds the default screen/paddle geometry, the paddle motion state enum
//   and the paddle colours used by the pixel mixer.
package pong_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int PADDLE_W    = 16;
    localparam int PADDLE_H    = 80;
    localparam int EDGE_MARGIN = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } paddle_state_e;

    // 4:4:4 RGB colours the mixer paints for left- and right-side paddles.
    localparam logic [11:0] PADDLE_COLOR_LEFT  = 12'hFFF;
    localparam logic [11:0] PADDLE_COLOR_RIGHT = 12'h0FF;

endpackage

// File: rtl/paddle_axis.sv
// One paddle: button synchroniser, motion FSM with speed ramp, clamped y, pixel hit test.
// Latency: buttons 2 clk sync then next tick; y/moving update on tick edge; paddle_on 1 clk after x,y.
// Backpressure: none; enable=0 freezes motion state and forces moving low.
//   Ports: clk, reset (sync, active-low), enable, tick (prescaler pulse),
//   btn_up_n/btn_dn_n (async active-low), x/y (pixel), paddle_on, x_paddle, y_paddle, moving.
module paddle_axis
    import pong_pkg::*;
#(
    parameter int X_CENTRE    = 28,
    parameter int HALF_W      = 8,
    parameter int HALF_H      = 40,
    parameter int Y_INIT      = 240,
    parameter int Y_MIN       = 40,
    parameter int Y_MAX       = 440,
    parameter int ACCEL_TICKS = 16,
    parameter int MAX_SPEED   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic       btn_up_n,
    input  logic       btn_dn_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       paddle_on,
    output logic [9:0] x_paddle,
    output logic [9:0] y_paddle,
    output logic       moving
);

    localparam int SPD_W  = $clog2(MAX_SPEED + 1);
    localparam int HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

    localparam logic [SPD_W-1:0]   SPD_ONE   = SPD_W'(1);
    localparam logic [SPD_W-1:0]   SPD_MAX   = SPD_W'(MAX_SPEED);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(ACCEL_TICKS - 1);
    localparam logic signed [10:0] Y_MIN_S   = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S   = 11'(Y_MAX);
    localparam logic signed [10:0] HALF_H_S  = 11'(HALF_H);
    localparam logic signed [10:0] X_LO_S    = 11'(X_CENTRE - HALF_W);
    localparam logic signed [10:0] X_HI_S    = 11'(X_CENTRE + HALF_W - 1);

    logic [1:0]          up_sync_q;
    logic [1:0]          dn_sync_q;
    logic                req_up;
    logic                req_dn;
    paddle_state_e       state_q, state_d;
    logic [SPD_W-1:0]    speed_q, speed_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [9:0]          y_q, y_d;
    logic                moving_q, moving_d;
    logic                on_q, on_d;

    logic signed [10:0]  y_ext;
    logic signed [10:0]  y_tgt;
    logic signed [10:0]  speed_ext;
    logic signed [10:0]  x_s;
    logic signed [10:0]  y_s;

    assign req_up = ~up_sync_q[1];
    assign req_dn = ~dn_sync_q[1];

    // Widen to 11-bit signed so neither the move nor the hit window can wrap.
    assign y_ext = signed'({1'b0, y_q});
    assign x_s   = signed'({1'b0, x});
    assign y_s   = signed'({1'b0, y});

    always_comb begin
        state_d   = state_q;
        speed_d   = speed_q;
        hold_d    = hold_q;
        y_d       = y_q;
        moving_d  = moving_q;
        y_tgt     = y_ext;
        speed_ext = 11'sd0;

        if (!enable) begin
            moving_d = 1'b0;
        end else if (tick) begin
            if (req_up && !req_dn) begin
                state_d = UP;
            end else if (req_dn && !req_up) begin
                state_d = DOWN;
            end else begin
                state_d = IDLE;
            end

            // Fresh direction (including a reversal) restarts the ramp.
            if (state_d != IDLE) begin
                if (state_d != state_q) begin
                    speed_d = SPD_ONE;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (speed_q < SPD_MAX) begin
                        speed_d = speed_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            speed_ext = signed'(11'(speed_d));
            case (state_d)
                UP: begin
                    y_tgt = y_ext - speed_ext;
                    if (y_tgt < Y_MIN_S) begin
                        y_tgt = Y_MIN_S;
                    end
                end
                DOWN: begin
                    y_tgt = y_ext + speed_ext;
                    if (y_tgt > Y_MAX_S) begin
                        y_tgt = Y_MAX_S;
                    end
                end
                default: y_tgt = y_ext;
            endcase

            y_d      = y_tgt[9:0];
            // Pinned against a bound or idle means no visible motion.
            moving_d = (y_d != y_q);
        end
    end

    assign on_d = (x_s >= X_LO_S) && (x_s <= X_HI_S) &&
                  (y_s >= (y_ext - HALF_H_S)) && (y_s <= (y_ext + HALF_H_S - 11'sd1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            up_sync_q <= 2'b11;
            dn_sync_q <= 2'b11;
            state_q   <= IDLE;
            speed_q   <= SPD_ONE;
            hold_q    <= '0;
            y_q       <= 10'(Y_INIT);
            moving_q  <= 1'b0;
            on_q      <= 1'b0;
        end else begin
            up_sync_q <= {up_sync_q[0], btn_up_n};
            dn_sync_q <= {dn_sync_q[0], btn_dn_n};
            state_q   <= state_d;
            speed_q   <= speed_d;
            hold_q    <= hold_d;
            y_q       <= y_d;
            moving_q  <= moving_d;
            on_q      <= on_d;
        end
    end

    assign paddle_on = on_q;
    assign x_paddle  = 10'(X_CENTRE);
    assign y_paddle  = y_q;
    assign moving    = moving_q;

endmodule

// File: rtl/paddle_bank.sv
// Bank of N_PADDLES player paddles sharing one move-tick prescaler.
// Latency: y_paddle/moving change 1 clk after prescaler wrap; paddle_on 1 clk after x,y.
// Backpressure: none; enable=0 freezes every paddle (prescaler keeps running).
//   Ports: clk, reset (sync, active-low), enable, btn_up_n/btn_dn_n[N], x, y,
//   paddle_on[N], x_paddle/y_paddle (10 bits per paddle, paddle i at [10i+9:10i]), moving[N].
module paddle_bank #(
    parameter int N_PADDLES   = 2,
    parameter int H_ACTIVE    = pong_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = pong_pkg::V_ACTIVE,
    parameter int PADDLE_W    = pong_pkg::PADDLE_W,
    parameter int PADDLE_H    = pong_pkg::PADDLE_H,
    parameter int EDGE_MARGIN = pong_pkg::EDGE_MARGIN,
    parameter int X_STRIDE    = 40,
    parameter int TICK_DIV    = 250000,
    parameter int ACCEL_TICKS = 16,
    parameter int MAX_SPEED   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_PADDLES-1:0]    btn_up_n,
    input  logic [N_PADDLES-1:0]    btn_dn_n,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    output logic [N_PADDLES-1:0]    paddle_on,
    output logic [10*N_PADDLES-1:0] x_paddle,
    output logic [10*N_PADDLES-1:0] y_paddle,
    output logic [N_PADDLES-1:0]    moving
);

    logic [31:0] div_q;
    logic        tick_q;

    // Registered tick: the wrap compare and the paddle update are one clk apart.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (div_q == 32'(TICK_DIV - 1)) begin
            div_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            div_q  <= div_q + 32'd1;
            tick_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_PADDLES; i++) begin : g_paddle
        localparam int PAIR  = i / 2;
        localparam int X_IN  = EDGE_MARGIN + PADDLE_W / 2 + PAIR * X_STRIDE;
        // Even paddles sit on the left, odd ones mirror them on the right.
        localparam int X_CEN = ((i % 2) == 0) ? X_IN : (H_ACTIVE - 1 - X_IN);

        paddle_axis #(
            .X_CENTRE    (X_CEN),
            .HALF_W      (PADDLE_W / 2),
            .HALF_H      (PADDLE_H / 2),
            .Y_INIT      (V_ACTIVE / 2),
            .Y_MIN       (PADDLE_H / 2),
            .Y_MAX       (V_ACTIVE - PADDLE_H / 2),
            .ACCEL_TICKS (ACCEL_TICKS),
            .MAX_SPEED   (MAX_SPEED)
        ) u_axis (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .tick      (tick_q),
            .btn_up_n  (btn_up_n[i]),
            .btn_dn_n  (btn_dn_n[i]),
            .x         (x),
            .y         (y),
            .paddle_on (paddle_on[i]),
            .x_paddle  (x_paddle[10*i +: 10]),
            .y_paddle  (y_paddle[10*i +: 10]),
            .moving    (moving[i])
        );
    end

endmodule

// File: tb/tb_paddle_bank.sv
// Directed bench for paddle_bank with a fast prescaler and short ramp.
// Latency: n/a.
// Backpressure: n/a.
module tb_paddle_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  btn_up_n;
    logic [1:0]  btn_dn_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  paddle_on;
    logic [19:0] x_paddle;
    logic [19:0] y_paddle;
    logic [1:0]  moving;

    logic [9:0]  y0, y1, x0, x1;
    assign y0 = y_paddle[9:0];
    assign y1 = y_paddle[19:10];
    assign x0 = x_paddle[9:0];
    assign x1 = x_paddle[19:10];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    paddle_bank #(
        .N_PADDLES   (2),
        .TICK_DIV    (4),
        .ACCEL_TICKS (4),
        .MAX_SPEED   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .btn_up_n  (btn_up_n),
        .btn_dn_n  (btn_dn_n),
        .x         (x),
        .y         (y),
        .paddle_on (paddle_on),
        .x_paddle  (x_paddle),
        .y_paddle  (y_paddle),
        .moving    (moving)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns #1 after the edge on which the paddles consume the next tick.
    task automatic next_tick();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            if (dut.tick_q) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $error("FAIL tick_timeout: observed no tick expected tick within 16 cycles");
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        btn_up_n = 2'b11;
        btn_dn_n = 2'b11;
        x        = 10'd0;
        y        = 10'd0;

        // Reset state
        cycles(3);
        chk("rst_y0", y0, 240);
        chk("rst_y1", y1, 240);
        chk("rst_x0", x0, 28);
        chk("rst_x1", x1, 611);
        chk("rst_moving", moving, 0);
        chk("rst_on", paddle_on, 0);

        reset = 1'b1;
        cycles(100);
        chk("idle_y0", y0, 240);
        chk("idle_y1", y1, 240);
        chk("idle_moving", moving, 0);

        // Hit test around paddle 0 (x 20..35, y 200..279) and paddle 1 (x 603..618)
        x = 10'd20;  y = 10'd200; cycles(1); chk("hit_20_200", paddle_on, 2'b01);
        x = 10'd36;  y = 10'd200; cycles(1); chk("hit_36_200", paddle_on, 2'b00);
        x = 10'd20;  y = 10'd280; cycles(1); chk("hit_20_280", paddle_on, 2'b00);
        x = 10'd35;  y = 10'd279; cycles(1); chk("hit_35_279", paddle_on, 2'b01);
        x = 10'd19;  y = 10'd240; cycles(1); chk("hit_19_240", paddle_on, 2'b00);
        x = 10'd611; y = 10'd240; cycles(1); chk("hit_611_240", paddle_on, 2'b10);
        x = 10'd619; y = 10'd240; cycles(1); chk("hit_619_240", paddle_on, 2'b00);
        x = 10'd0;   y = 10'd0;

        // Paddle 0 up for 20 ticks: speeds 1x4, 2x4, 3x4, 4x8
        btn_up_n = 2'b10;
        cycles(3);
        for (int t = 1; t <= 20; t++) begin
            next_tick();
            if (t == 1)  chk("up_t1",  y0, 239);
            if (t == 4)  chk("up_t4",  y0, 236);
            if (t == 5)  chk("up_t5",  y0, 234);
            if (t == 8)  chk("up_t8",  y0, 228);
            if (t == 12) chk("up_t12", y0, 216);
            if (t == 16) chk("up_t16", y0, 200);
        end
        chk("up_t20", y0, 184);
        chk("up_moving", moving, 2'b01);
        chk("up_y1_still", y1, 240);

        btn_up_n = 2'b11;
        cycles(3);
        next_tick();
        chk("rel_y0", y0, 184);
        chk("rel_moving", moving, 0);

        // Freeze: 5 ticks (1,1,1,1,2) then enable=0, then resume at speed 2
        btn_up_n = 2'b10;
        cycles(3);
        repeat (5) next_tick();
        chk("frz_pre_y0", y0, 178);
        chk("frz_pre_moving", moving, 2'b01);
        enable = 1'b0;
        repeat (3) next_tick();
        chk("frz_y0", y0, 178);
        chk("frz_moving", moving, 0);
        enable = 1'b1;
        next_tick();
        chk("resume_y0", y0, 176);
        chk("resume_moving", moving, 2'b01);

        // Both buttons: paddle stays put
        btn_dn_n = 2'b10;
        cycles(3);
        repeat (3) next_tick();
        chk("both_y0", y0, 176);
        chk("both_moving", moving, 0);
        btn_up_n = 2'b11;
        btn_dn_n = 2'b11;
        cycles(3);

        // Paddle 1 down until clamp at 440 (reached on tick 56)
        btn_dn_n = 2'b01;
        cycles(3);
        for (int t = 1; t <= 60; t++) begin
            next_tick();
            chk("dn_bound", (y1 <= 10'd440), 1);
            if (t == 12) chk("dn_t12", y1, 264);
            if (t == 56) chk("dn_t56", y1, 440);
        end
        chk("dn_final", y1, 440);
        chk("dn_clamp_moving", moving, 0);
        chk("dn_y0_still", y0, 176);
        btn_dn_n = 2'b11;

        // Reach speed 3 on paddle 0, then reset mid-move
        btn_up_n = 2'b10;
        cycles(3);
        repeat (9) next_tick();
        chk("pre_rst_y0", y0, 161);
        reset = 1'b0;
        cycles(1);
        chk("mid_rst_y0", y0, 240);
        chk("mid_rst_y1", y1, 240);
        chk("mid_rst_moving", moving, 0);
        reset = 1'b1;
        next_tick();
        chk("post_rst_y0", y0, 239);
        chk("post_rst_moving", moving, 2'b01);
        btn_up_n = 2'b11;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_bank.md
# paddle_bank

Parametrised bank of N player-controlled paddles for the VGA pong core. It replaces the fixed two-paddle controller with:
- a shared move-tick prescaler;
- synchronised active-low buttons;
- per-paddle speed ramp with saturating vertical bounds;
- registered pixel hit-test.

It sits between the board buttons and the pixel mixer/ball-collision logic.

## Interface
Parameters:
- N_PADDLES, 2: number of paddles (1..4); even index on left side, odd index on right side.
- H_ACTIVE, 640: visible width.
- V_ACTIVE, 480: visible height.
- PADDLE_W, 16: paddle width, pixels.
- PADDLE_H, 80: paddle height, pixels.
- EDGE_MARGIN, 20: gap from screen edge to outermost paddle.
- X_STRIDE, 40: extra inward offset per paddle pair.
- TICK_DIV, 250000: clk cycles per move tick (1 ms at 250 MHz / 10 ms at 25 MHz…).
- ACCEL_TICKS, 16: held ticks per speed increment.
- MAX_SPEED, 4: max pixels moved per tick.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-low.
- enable  in  1  1 = movement allowed; 0 = freeze positions (score pause).
- btn_up_n  in  N_PADDLES  active-low up request, asynchronous to clk.
- btn_dn_n  in  N_PADDLES  active-low down request, asynchronous to clk.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- paddle_on  out  N_PADDLES  pixel (x,y) inside paddle i, registered.
- x_paddle  out  10*N_PADDLES  centre column of paddle i, bits [10i+9:10i].
- y_paddle  out  10*N_PADDLES  centre row of paddle i.
- moving  out  N_PADDLES  paddle i moved on the last tick.

## Operation
- Input sync: each button goes through two flops, then is inverted to req_up/req_dn.
- Prescaler: 32-bit counter counts 0..TICK_DIV-1. tick pulses for one cycle when the counter wraps. Counter runs regardless of enable.
- X centre (constant): paddle i, pair p=i/2.
  - Even i: EDGE_MARGIN + PADDLE_W/2 + p*X_STRIDE.
  - Odd i: H_ACTIVE-1 - (EDGE_MARGIN + PADDLE_W/2 + p*X_STRIDE).
- Per-paddle FSM, states IDLE, UP, DOWN. Evaluated only on tick with enable=1:
  - req_up & !req_dn → UP.
  - req_dn & !req_up → DOWN.
  - both or neither → IDLE.
  - Entering UP/DOWN from a different state sets speed=1 and hold=0.
  - Staying in UP/DOWN increments hold. When hold reaches ACCEL_TICKS-1, hold returns to 0 and speed = min(speed+1, MAX_SPEED).
- Position update, same tick, using the new state:
  - UP: y ← max(y-speed, PADDLE_H/2).
  - DOWN: y ← min(y+speed, V_ACTIVE-PADDLE_H/2).
  - Arithmetic is in 11-bit signed/extended form, so subtraction never wraps.
  - At a bound, y is clamped and moving=0.
  - IDLE: y is held and moving=0.
- enable=0: state, speed, hold, y and moving are all held; moving is forced 0.
- Hit test, registered:
  - Horizontal: x_paddle-PADDLE_W/2 ≤ x ≤ x_paddle+PADDLE_W/2-1.
  - Vertical: y_paddle-PADDLE_H/2 ≤ y ≤ y_paddle+PADDLE_H/2-1.
  - Compares are 11-bit, so the low edge at row 0 does not underflow.

## Timing
- Reset (reset=0 at a clk edge), every paddle:
  - y_paddle=V_ACTIVE/2 (240), x_paddle per formula (28 / 611 for the default).
  - state IDLE, speed=1, hold=0.
  - moving=0, paddle_on=0, prescaler=0.
- Reset mid-move wins over tick/enable on the same edge.
- Button → visible in FSM: 2 cycles of sync, then the next tick.
- y_paddle/moving update on the clk edge where tick=1 (1 cycle after the wrap compare).
- paddle_on latency: 1 cycle after x,y. The mixer delays its own x/y-derived signals by 1.
- Reversal UP→DOWN within one tick restarts at speed 1.

## Structure
- Package pong_pkg holds:
  - H_ACTIVE, V_ACTIVE, PADDLE_W, PADDLE_H, EDGE_MARGIN as shared constants.
  - Paddle state enum (IDLE/UP/DOWN).
  - Paddle colour constants used by the mixer.
- Sub-module paddle_axis: one paddle's sync flops, FSM, speed ramp, clamp and hit compare.
- paddle_bank instantiates the prescaler once plus N_PADDLES paddle_axis instances in a generate loop.

## Test plan
Tests use TICK_DIV=4, ACCEL_TICKS=4, MAX_SPEED=4, default geometry.
- Reset, then idle 100 cycles → y_paddle=240 for both; x_paddle = 28 and 611; moving=0.
- Paddle 0 btn_up_n=0 held for 20 ticks:
  - Speed steps 1,1,1,1,2,2,2,2,3,…,4.
  - y after 20 ticks = 240-(4+8+12+16+16) = 184.
- Paddle 1 btn_dn_n=0 held long → y saturates at 440 and never exceeds it; moving drops to 0 at the clamp.
- Both buttons low on paddle 0 → y constant. enable=0 while btn_up_n=0 → y frozen; on release of enable, speed resumes at its held value.
- Hit test with y_paddle0=240:
  - (x=20,y=200) → paddle_on[0]=1 next cycle.
  - (x=36,y=200) and (x=20,y=280) → 0.
- Reset asserted while moving at speed 3 → next cycle y=240 and speed=1; the first move after reset is 1 px.
